dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Initiator side of the single-port synchronous data memory used by the SimpleRISC core's MEM stage.
- Accepts word-wide ld/st requests from the pipeline over a valid/ready handshake and drives the memory's re/we/addr/wdata.
- Absorbs the memory's 1-cycle registered read latency and returns results over a second valid/ready handshake.
- Rejects misaligned or out-of-range accesses without touching memory; keeps saturating event counters.

Parameters:
- MEM_WORDS, 1024: words in the attached memory; legal byte addresses are 0 to 4*MEM_WORDS-4.
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store (st), 0 = load (ld).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline takes the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- resp_is_load  out  1  response belongs to a load.
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered inside memory, valid the cycle after mem_re.
- cnt_load  out  CNT_W  completed good loads.
- cnt_store  out  CNT_W  completed good stores.
- cnt_err  out  CNT_W  rejected requests.

Behaviour:
- States: IDLE, RD_WAIT, RESP.
- req_ready = 1 only in IDLE; forced 0 while rst_n low.
- Accept: req_valid & req_ready at a rising edge.
- Legality: bad = (req_addr[1:0] != 0) | (req_addr >= 4*MEM_WORDS).
- Memory-side outputs are combinational in IDLE:
  - mem_addr = req_addr; mem_wdata = req_wdata.
  - mem_we = req_valid & req_we & ~bad.
  - mem_re = req_valid & ~req_we & ~bad.
  - In every other state, and while rst_n low, mem_re = mem_we = 0. mem_addr and mem_wdata are don't-care when both enables are 0.
- Good store accepted in cycle N: write occurs at the edge ending N. Next state RESP; resp_valid from N+1 with resp_is_load=0, resp_err=0, resp_rdata=0.
- Good load accepted in cycle N: next state RD_WAIT (cycle N+1), during which mem_rdata is captured into resp_rdata at the edge ending N+1. Next state RESP; resp_valid from N+2 with resp_is_load=1. Load-to-response latency is 2 cycles.
- Bad request accepted in N: no memory enable asserted. Next state RESP; resp_valid from N+1 with resp_err=1, resp_rdata=0, resp_is_load=~req_we.
- RESP: resp_valid=1; resp_rdata, resp_err and resp_is_load are held stable until resp_valid & resp_ready; then IDLE.
- No new request is accepted in the cycle a response is consumed. Peak throughput is one store per 2 cycles or one load per 3 cycles.
- mem_rdata is sampled only in RD_WAIT. Its value in any other cycle is ignored.
- Counters increment once per response handshake:
  - cnt_load: good load.
  - cnt_store: good store.
  - cnt_err: bad request.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Reset (asynchronous, any state, including RD_WAIT mid-load):
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; resp_is_load = 0; all counters = 0.
  - mem_re, mem_we and req_ready are forced to 0 immediately.
  - An in-flight load is discarded. A store whose edge coincides with reset assertion is not guaranteed.
- req_* inputs are ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
- Reset, then st addr 0x10 data 0xDEADBEEF, resp_ready=1 -> mem_we=1 for 1 cycle with mem_addr=0x10; resp_valid at N+1, resp_err=0; cnt_store=1.
- Then ld 0x10 -> mem_re=1 in N; resp_valid at N+2 with resp_rdata=0xDEADBEEF, resp_is_load=1; cnt_load=1.
- Ld 0x12 (misaligned), and separately st 0x1000 with MEM_WORDS=1024 -> no mem_re/mem_we ever; resp_err=1 at N+1; cnt_err=2.
- Ld 0x20 with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable throughout; req_ready=0; memory-side data changes are ignored; one handshake when resp_ready rises.
- Assert rst_n low in RD_WAIT -> same cycle: req_ready=0, mem_re=0. After release: resp_valid=0, counters=0, IDLE, next ld 0x10 returns 0xDEADBEEF.
- CNT_W=2, 5 good stores -> cnt_store saturates at 3.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Initiator side of the single-port synchronous data memory used by the
//   MEM stage. Takes word ld/st requests over a valid/ready handshake, drives
//   the memory enables, absorbs the memory's one-cycle registered read and
//   returns the result over a second valid/ready handshake. Misaligned or
//   out-of-range requests are answered with resp_err and never reach memory.
//   Saturating counters record completed good loads, good stores and errors.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr, req_wdata   request: 1 = store, byte address, store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err, resp_is_load   response payload
//   mem_re, mem_we, mem_addr, mem_wdata  memory command (combinational in IDLE)
//   mem_rdata                  memory read data, valid the cycle after mem_re
//   cnt_load, cnt_store, cnt_err   saturating event counters
//
// State | meaning
//   IDLE    | ready for a request; memory command driven straight from req_*
//   RD_WAIT | good load issued last cycle; capture mem_rdata this cycle
//   RESP    | response presented; held until resp_valid & resp_ready

module dmem_access_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             resp_is_load,
  output logic             mem_re,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  // One extra bit so the limit stays exact even when 4*MEM_WORDS reaches 2^32.
  localparam logic [32:0] ADDR_LIMIT = 33'(longint'(MEM_WORDS) * 4);

  logic [1:0]       state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             is_load_q, is_load_d;
  logic [CNT_W-1:0] cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0] cnt_store_q, cnt_store_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  logic in_idle;
  logic addr_bad;
  logic accept;
  logic resp_done;

  // rst_n gates the combinational outputs so they drop the instant reset
  // asserts, not just after the state register clears.
  assign in_idle  = rst_n & (state_q == ST_IDLE);
  assign addr_bad = (req_addr[1:0] != 2'b00) | ({1'b0, req_addr} >= ADDR_LIMIT);
  assign accept   = in_idle & req_valid;

  assign req_ready = in_idle;
  assign mem_we    = accept & req_we & ~addr_bad;
  assign mem_re    = accept & ~req_we & ~addr_bad;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign resp_valid   = (state_q == ST_RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign resp_is_load = is_load_q;
  assign resp_done    = (state_q == ST_RESP) & resp_ready;

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_err   = cnt_err_q;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    is_load_d = is_load_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d     = addr_bad;
          is_load_d = ~req_we;
          rdata_d   = '0;
          state_d   = (addr_bad | req_we) ? ST_RESP : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        rdata_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_load_d  = cnt_load_q;
    cnt_store_d = cnt_store_q;
    cnt_err_d   = cnt_err_q;
    if (resp_done) begin
      if (err_q) begin
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
      end else if (is_load_q) begin
        if (cnt_load_q != '1) cnt_load_d = cnt_load_q + CNT_W'(1);
      end else begin
        if (cnt_store_q != '1) cnt_store_d = cnt_store_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      is_load_q   <= 1'b0;
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      is_load_q   <= is_load_d;
      cnt_load_q  <= cnt_load_d;
      cnt_store_q <= cnt_store_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam int     MEM_WORDS = 1024;
  localparam int     CNT_W     = 16;
  localparam int     AW        = $clog2(MEM_WORDS);
  localparam longint CNT_MAX   = (64'd1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, resp_is_load, mem_re, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] cnt_load, cnt_store, cnt_err;

  // second instance with narrow counters for the saturation check
  logic        req_valid2, req_we2, resp_ready2;
  logic [31:0] req_addr2, req_wdata2;
  logic        req_ready2, resp_valid2, resp_err2, resp_is_load2, mem_re2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
  logic [31:0] mem_rdata2 = 32'h0;
  logic [1:0]  cnt_load2, cnt_store2, cnt_err2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_is_load(resp_is_load),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
  );

  dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2),
    .resp_err(resp_err2), .resp_is_load(resp_is_load2),
    .mem_re(mem_re2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2),
    .cnt_load(cnt_load2), .cnt_store(cnt_store2), .cnt_err(cnt_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: registered read, and garbage on the read port in
  // every cycle that did not follow a read.
  logic [31:0] mem_arr [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr[AW+1:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_arr[mem_addr[AW+1:2]];
    else        mem_rdata <= $urandom;
  end

  // Transaction-level reference: one outstanding request, a latency count
  // until its response shows, and a shadow copy of memory contents.
  logic        m_busy;
  int          m_lat;
  logic [31:0] m_rdata;
  logic        m_err, m_isl;
  longint      m_cl, m_cs, m_ce;
  logic [31:0] shadow [MEM_WORDS];
  logic        m_bad, m_ewe, m_ere, m_rv;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_mem_re", 32'(mem_re), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_cnt_load", 32'(cnt_load), 32'h0);
      chk("rst_cnt_store", 32'(cnt_store), 32'h0);
      chk("rst_cnt_err", 32'(cnt_err), 32'h0);
      m_busy = 1'b0; m_lat = 0; m_cl = 0; m_cs = 0; m_ce = 0;
    end else begin
      m_rv  = m_busy && (m_lat == 0);
      m_bad = (req_addr[1:0] != 2'b00) || (longint'(req_addr) >= longint'(MEM_WORDS) * 4);
      m_ewe = !m_busy && req_valid && req_we && !m_bad;
      m_ere = !m_busy && req_valid && !req_we && !m_bad;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_is_load", 32'(resp_is_load), 32'(m_isl));
      end
      chk("mem_we", 32'(mem_we), 32'(m_ewe));
      chk("mem_re", 32'(mem_re), 32'(m_ere));
      if (m_ewe || m_ere) chk("mem_addr", mem_addr, req_addr);
      if (m_ewe) chk("mem_wdata", mem_wdata, req_wdata);
      chk("cnt_load", 32'(cnt_load), 32'(m_cl));
      chk("cnt_store", 32'(cnt_store), 32'(m_cs));
      chk("cnt_err", 32'(cnt_err), 32'(m_ce));
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1;
          m_rdata = 32'h0;
          m_err = m_bad;
          m_isl = !req_we;
          if (m_bad || req_we) m_lat = 0;
          else begin
            m_lat = 1;
            m_rdata = shadow[req_addr[AW+1:2]];
          end
          if (!m_bad && req_we) shadow[req_addr[AW+1:2]] = req_wdata;
        end
      end else if (m_lat > 0) begin
        m_lat--;
      end else if (resp_ready) begin
        m_busy = 1'b0;
        if (m_err)      m_ce = (m_ce < CNT_MAX) ? m_ce + 1 : m_ce;
        else if (m_isl) m_cl = (m_cl < CNT_MAX) ? m_cl + 1 : m_cl;
        else            m_cs = (m_cs < CNT_MAX) ? m_cs + 1 : m_cs;
      end
    end
  end

  // Issue one request; report response latency (cycles after the accept
  // cycle) and payload. hold > 0 keeps resp_ready low that many extra cycles.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output int lat, output logic [31:0] rd,
                        output logic er, output logic il);
    int n;
    @(posedge clk); #1;
    resp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) chk("req_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    if (!resp_valid) chk("resp_arrive", 32'(resp_valid), 32'h1);
    rd = resp_rdata; er = resp_err; il = resp_is_load;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic store2(input logic [31:0] addr);
    int n;
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = addr; req_wdata2 = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready2 && n < 20);
    if (!req_ready2) chk("req2_accept", 32'(req_ready2), 32'h1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid2 && n < 20);
    if (!resp_valid2) chk("resp2_arrive", 32'(resp_valid2), 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er, il;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    req_valid2 = 0; req_we2 = 0; req_addr2 = 0; req_wdata2 = 0; resp_ready2 = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("init_req_ready", 32'(req_ready), 32'h1);
    chk("init_resp_valid", 32'(resp_valid), 32'h0);
    chk("init_cnt_store", 32'(cnt_store), 32'h0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 0, lat, rd, er, il);
    chk("st10_lat", lat, 1);
    chk("st10_err", 32'(er), 0);
    chk("st10_isl", 32'(il), 0);
    chk("st10_rdata", rd, 0);
    chk("st10_cnt_store", 32'(cnt_store), 1);

    do_req(1'b0, 32'h10, 32'h0, 0, lat, rd, er, il);
    chk("ld10_lat", lat, 2);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_isl", 32'(il), 1);
    chk("ld10_cnt_load", 32'(cnt_load), 1);

    do_req(1'b0, 32'h12, 32'h0, 0, lat, rd, er, il);
    chk("ld12_lat", lat, 1);
    chk("ld12_err", 32'(er), 1);
    chk("ld12_isl", 32'(il), 1);
    chk("ld12_rdata", rd, 0);

    do_req(1'b1, 32'h1000, 32'h55, 0, lat, rd, er, il);
    chk("st1000_lat", lat, 1);
    chk("st1000_err", 32'(er), 1);
    chk("st1000_isl", 32'(il), 0);
    chk("bad_cnt_err", 32'(cnt_err), 2);

    do_req(1'b1, 32'hFFC, 32'hCAFEF00D, 0, lat, rd, er, il);
    chk("stFFC_err", 32'(er), 0);
    do_req(1'b0, 32'hFFC, 32'h0, 0, lat, rd, er, il);
    chk("ldFFC_rdata", rd, 32'hCAFEF00D);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 0, lat, rd, er, il);
    chk("ldtop_err", 32'(er), 1);
    chk("ldtop_cnt_err", 32'(cnt_err), 3);

    do_req(1'b1, 32'h20, 32'h12345678, 0, lat, rd, er, il);
    do_req(1'b0, 32'h20, 32'h0, 5, lat, rd, er, il);
    chk("ld20_hold_lat", lat, 2);
    chk("ld20_hold_rdata", rd, 32'h12345678);
    chk("ld20_cnt_load", 32'(cnt_load), 3);

    // back-to-back stores with req_valid held high: one accept per 2 cycles
    @(posedge clk); #1;
    resp_ready = 1; req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hA5A5_0001;
    repeat (6) @(posedge clk);
    #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 chk("burst_cnt_store", 32'(cnt_store), 6);

    // reset while a load sits in RD_WAIT
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rdw_rst_req_ready", 32'(req_ready), 0);
    chk("rdw_rst_mem_re", 32'(mem_re), 0);
    chk("rdw_rst_resp_valid", 32'(resp_valid), 0);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    #1;
    chk("rst_valid_mem_re", 32'(mem_re), 0);
    chk("rst_valid_req_ready", 32'(req_ready), 0);
    req_valid = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_resp_valid", 32'(resp_valid), 0);
    chk("post_rst_cnt_load", 32'(cnt_load), 0);
    chk("post_rst_cnt_store", 32'(cnt_store), 0);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    do_req(1'b0, 32'h10, 32'h0, 0, lat, rd, er, il);
    chk("post_rst_ld10_rdata", rd, 32'hDEADBEEF);
    chk("post_rst_cnt_load1", 32'(cnt_load), 1);

    for (int i = 1; i <= 5; i++) begin
      store2(32'(i * 4));
      chk($sformatf("sat_store_%0d", i), 32'(cnt_store2), (i < 3) ? i : 3);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
